// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface ifetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/ifetch_unit.sv
// MIPS instruction fetch stage: PC, imem handshake, skid buffer and IF/ID register.
// Define BRANCH_DELAY_SLOT_EN to deliver the word after a branch/jump instead of squashing it.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect_branch,
  input  logic [31:0]   branch_target,
  input  logic          redirect_jump,
  ifetch_unit_if.master imem,
  output logic [31:0]   if_instr,
  output logic [5:0]    if_op,
  output logic [31:0]   if_pc4,
  output logic          if_valid
);
  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r, hold_addr_r, skid_r, pend_tgt_r, instr_r, pc4_r;
  logic        pend_r, valid_r;
  logic        redirect_s, accept_s, miss_s, squash_s, req_s;
  logic [31:0] target_s, pc_plus4_s, next_pc_s, word_s;

  // Redirect decode, request gating and the per-cycle capture decision.
  always_comb begin
    redirect_s = !stall && (redirect_jump || redirect_branch);
    if (redirect_jump) begin
      target_s = {pc4_r[31:28], instr_r[25:0], 2'b00};
    end else begin
      target_s = branch_target & 32'hFFFF_FFFC;
    end
    pc_plus4_s = pc_r + 32'd4;
    word_s     = (state_r == HOLD) ? skid_r : imem.rdata;
    // accept_s: a word lands in IF/ID this edge; miss_s: request stays outstanding with stall low
    case (state_r)
      ISSUE: begin
        req_s    = !stall;
        accept_s = !stall && imem.ready;
        miss_s   = !stall && !imem.ready;
      end
      WAIT: begin
        req_s    = 1'b1;
        accept_s = !stall && imem.ready;
        miss_s   = !stall && !imem.ready;
      end
      HOLD: begin
        req_s    = 1'b0;
        accept_s = !stall;
        miss_s   = 1'b0;
      end
      DROP: begin
        req_s    = 1'b1;
        accept_s = 1'b0;
        miss_s   = 1'b0;
      end
      default: begin
        req_s    = 1'b0;
        accept_s = 1'b0;
        miss_s   = 1'b0;
      end
    endcase
`ifdef BRANCH_DELAY_SLOT_EN
    squash_s = 1'b0;
    if (redirect_s) begin
      next_pc_s = target_s;
    end else if (pend_r) begin
      next_pc_s = pend_tgt_r;
    end else begin
      next_pc_s = pc_plus4_s;
    end
`else
    squash_s  = redirect_s;
    next_pc_s = pc_plus4_s;
`endif
  end

  assign imem.req  = req_s && !reset;
  assign imem.addr = (state_r == ISSUE) ? pc_r : hold_addr_r;
  assign if_instr  = instr_r;
  assign if_op     = instr_r[31:26];
  assign if_pc4    = pc4_r;
  assign if_valid  = valid_r;

  // Fetch FSM together with PC, pending redirect, skid buffer and IF/ID updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ISSUE;
      pc_r        <= RESET_PC;
      hold_addr_r <= RESET_PC;
      skid_r      <= 32'd0;
      pend_r      <= 1'b0;
      pend_tgt_r  <= 32'd0;
      instr_r     <= 32'd0;
      pc4_r       <= 32'd0;
      valid_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        pend_r <= 1'b0;
        if (squash_s) begin
          valid_r <= 1'b0;
          pc_r    <= target_s;
        end else begin
          instr_r <= word_s;
          pc4_r   <= pc_plus4_s;
          valid_r <= 1'b1;
          pc_r    <= next_pc_s;
        end
      end else if (miss_s) begin
        valid_r <= 1'b0;
        if (redirect_s) begin
          pend_r     <= 1'b1;
          pend_tgt_r <= target_s;
`ifndef BRANCH_DELAY_SLOT_EN
          pc_r       <= target_s;
`endif
        end
      end else if (state_r == DROP && imem.ready && pend_r) begin
        pend_r <= 1'b0;
        pc_r   <= pend_tgt_r;
      end

      case (state_r)
        ISSUE: begin
          hold_addr_r <= pc_r;
          if (miss_s) state_r <= squash_s ? DROP : WAIT;
        end
        WAIT: begin
          if (imem.ready) begin
            if (stall) begin
              skid_r  <= imem.rdata;
              state_r <= HOLD;
            end else begin
              state_r <= ISSUE;
            end
          end else if (miss_s && squash_s) begin
            state_r <= DROP;
          end
        end
        HOLD: if (!stall) state_r <= ISSUE;
        DROP: if (imem.ready) state_r <= ISSUE;
        default: state_r <= ISSUE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed test-plan sequence, then randomized traffic,
// every cycle compared against a flag-level behavioural model of the fetch stage.
module tb_ifetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0040;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit BDS = 1'b1;
`else
  localparam bit BDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, redirect_branch, redirect_jump;
  logic [31:0] branch_target;
  logic [31:0] if_instr, if_pc4;
  logic [5:0]  if_op;
  logic        if_valid;
  int          n_checks = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ifetch_unit_if imem ();

  ifetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_branch(redirect_branch), .branch_target(branch_target),
    .redirect_jump(redirect_jump), .imem(imem),
    .if_instr(if_instr), .if_op(if_op), .if_pc4(if_pc4), .if_valid(if_valid)
  );

  // Memory image: one J instruction (index 26'h40) at 0x1000_0000, a hash of the address elsewhere.
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h1000_0000) return 32'h0800_0040;
    else return a ^ 32'hA5A5_0000;
  endfunction

  assign imem.rdata = memword(imem.addr);

  // Behavioural model state
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_held, m_skid, m_ptgt, m_instr, m_pc4;
  logic        m_out, m_drop, m_skid_full, m_pend, m_valid, m_fresh;

  function automatic logic exp_req();
    if (reset) return 1'b0;
    else return !m_skid_full && (m_out || !stall);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_out ? m_held : m_pc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic deliver(input logic [31:0] w, input logic redir, input logic [31:0] t);
    if (BDS) begin
      m_instr = w;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_fresh = 1'b1;
      m_pc    = redir ? t : (m_pend ? m_ptgt : m_pc + 32'd4);
      m_pend  = 1'b0;
    end else if (redir) begin
      m_valid = 1'b0;
      m_pc    = t;
    end else begin
      m_instr = w;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_fresh = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
  endtask

  task automatic model_step();
    logic        rq, redir;
    logic [31:0] t, w;
    if (reset) begin
      m_known = 1'b1; m_pc = RPC; m_held = RPC; m_out = 1'b0; m_drop = 1'b0;
      m_skid_full = 1'b0; m_skid = 32'd0; m_pend = 1'b0; m_ptgt = 32'd0;
      m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_fresh = 1'b0;
    end else if (m_known) begin
      rq    = exp_req();
      w     = memword(exp_addr());
      redir = !stall && (redirect_jump || redirect_branch);
      t     = redirect_jump ? {m_pc4[31:28], m_instr[25:0], 2'b00} : branch_target;
      if (!stall) m_fresh = 1'b0;
      if (m_skid_full) begin
        if (!stall) begin
          deliver(m_skid, redir, t);
          m_skid_full = 1'b0;
        end
      end else if (rq) begin
        if (imem.ready) begin
          m_out = 1'b0;
          if (m_drop) m_drop = 1'b0;
          else if (stall) begin
            m_skid_full = 1'b1;
            m_skid = w;
          end else deliver(w, redir, t);
        end else begin
          if (!m_out) begin
            m_out  = 1'b1;
            m_held = m_pc;
          end
          if (!stall && !m_drop) begin
            m_valid = 1'b0;
            if (redir && BDS) begin
              m_pend = 1'b1;
              m_ptgt = t;
            end else if (redir) begin
              m_drop = 1'b1;
              m_pc   = t;
            end
          end
        end
      end
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (m_known) begin
      check("req", {31'd0, imem.req}, {31'd0, exp_req()});
      if (exp_req()) check("addr", imem.addr, exp_addr());
      check("valid", {31'd0, if_valid}, {31'd0, m_valid});
      check("instr", if_instr, m_instr);
      check("op", {26'd0, if_op}, {26'd0, m_instr[31:26]});
      check("pc4", if_pc4, m_pc4);
    end
  end

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply(input logic rst, input logic st, input logic rb, input logic rj,
                       input logic [31:0] bt, input logic rdy);
    reset = rst; stall = st; redirect_branch = rb; redirect_jump = rj;
    branch_target = bt; imem.ready = rdy;
    @(negedge clk);
  endtask

  task automatic cyc(input logic rst, input logic st, input logic rb, input logic rj,
                     input logic [31:0] bt, input logic rdy);
    advance();
    apply(rst, st, rb, rj, bt, rdy);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_branch = 1'b0; redirect_jump = 1'b0;
    branch_target = 32'd0; imem.ready = 1'b0;

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("rst_req", {31'd0, imem.req}, 32'd0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc4", if_pc4, 32'd0);

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);                 // A
    check("A_addr", imem.addr, 32'h0000_0040);
    check("A_valid", {31'd0, if_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);                 // B
    check("B_addr", imem.addr, 32'h0000_0044);
    check("B_instr", if_instr, 32'hA5A5_0040);
    check("B_pc4", if_pc4, 32'h0000_0044);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 1'b1);         // C: branch to 0x8
    check("C_addr", imem.addr, 32'h0000_0048);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);                 // D
    check("D_addr", imem.addr, 32'h0000_0008);
    check("D_slot_valid", {31'd0, if_valid}, {31'd0, BDS});
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);                 // E
    check("E_addr", imem.addr, 32'h0000_0008);
    check("E_bubble", {31'd0, if_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);                 // F
    check("F_addr", imem.addr, 32'h0000_0008);
    check("F_bubble", {31'd0, if_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h1000_0000, 1'b1);         // G
    check("G_instr", if_instr, 32'hA5A5_0008);
    check("G_pc4", if_pc4, 32'h0000_000C);
    check("G_addr", imem.addr, 32'h0000_000C);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);                 // H
    check("H_addr", imem.addr, 32'h1000_0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);                 // I: jump, memory waits
    check("I_instr", if_instr, 32'h0800_0040);
    check("I_op", {26'd0, if_op}, 32'h0000_0002);
    check("I_pc4", if_pc4, 32'h1000_0004);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);                 // J
    check("J_addr", imem.addr, 32'h1000_0004);
    check("J_valid", {31'd0, if_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);                 // K
    check("K_addr", imem.addr, 32'h1000_0100);
    check("K_valid", {31'd0, if_valid}, {31'd0, BDS});
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);                 // L: stall while waiting
    check("L_req", {31'd0, imem.req}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);                 // M
    check("M_req", {31'd0, imem.req}, 32'd0);
    check("M_instr", if_instr, BDS ? 32'hB5A5_0004 : 32'h0800_0040);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);                 // N
    check("N_req", {31'd0, imem.req}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);                 // O
    check("O_instr", if_instr, 32'hB5A5_0100);
    check("O_pc4", if_pc4, 32'h1000_0104);
    check("O_addr", imem.addr, 32'h1000_0104);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);                 // P: reset during WAIT
    check("P_req", {31'd0, imem.req}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);                 // Q
    check("Q_addr", imem.addr, 32'h0000_0040);
    check("Q_valid", {31'd0, if_valid}, 32'd0);

    for (int i = 0; i < 4000; i++) begin
      logic        r, s, b, j, rdy;
      logic [31:0] t;
      advance();
      r   = ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      t   = $urandom_range(0, 255) << 2;
      b   = 1'b0;
      j   = 1'b0;
      if (!s && m_valid && m_fresh && !m_pend && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) j = 1'b1;
        else b = 1'b1;
      end
      apply(r, s, b, j, t, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the MIPS datapath, directly upstream of the opcode decoder. It owns the program counter, issues requests to instruction memory with a ready handshake, and holds the IF/ID register whose `if_op` field drives the control unit. It also applies redirects from that decoder's branch/jump outcome and supports hazard stalls.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hazard hold: freezes the PC and the IF/ID register, and blocks new requests.
- `redirect_branch`  in  1  taken branch decoded from `if_instr`; valid only while `stall`=0.
- `branch_target`  in  32  byte address for a taken branch.
- `redirect_jump`  in  1  J/JAL decoded from `if_instr`; valid only while `stall`=0. Wins over `redirect_branch`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready`  in  1  `imem_rdata` is valid this cycle for the held request.
- `imem_rdata`  in  32  instruction word.
- `if_instr`  out  32  IF/ID instruction word.
- `if_op`  out  6  `if_instr[31:26]`, feeds the control unit.
- `if_pc4`  out  32  PC+4 of `if_instr`, used for the JAL link value and branch base.
- `if_valid`  out  1  `if_instr` is a real instruction; 0 means bubble.

## Operation
- Jump target: {`if_pc4[31:28]`, `if_instr[25:0]`, 2'b00}. Branch target is taken from `branch_target` as given.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] of the PC are always 0.
- FSM states:
  - **ISSUE**: `imem_req`=1 when `stall`=0.
    - `imem_ready`=1: capture the word (`if_valid`←1, `if_pc4`←pc+4) and set pc←next_pc.
    - `imem_ready`=0: go to WAIT. `if_valid`←0 if `stall`=0.
  - **WAIT**: `imem_req`=1, address held.
    - Ready with `stall`=0: capture and go to ISSUE.
    - Ready with `stall`=1: store the word in the skid buffer and go to HOLD.
  - **HOLD**: `imem_req`=0. When `stall` falls, deliver the buffered word into IF/ID and go to ISSUE.
  - **DROP**: `imem_req`=1, address held. When ready, discard the data (`if_valid` stays 0), load pc←pending target, and go to ISSUE.
- next_pc is pc+4, or the redirect target as described below.
- Redirect without delay slot (macro undefined):
  - Any word fetched in the same cycle as the redirect is discarded, and `if_valid`←0.
  - pc←target.
  - If a request is outstanding (WAIT), go to DROP.
- `stall`=1 in ISSUE: `imem_req`=0; the PC and IF/ID hold.
- Reset values: pc=`RESET_PC`, state=ISSUE, `if_valid`=0, `if_instr`=0 (NOP), `if_op`=0, `if_pc4`=0, `imem_req`=0 during the reset cycle, skid buffer cleared, redirect-pending flag cleared.
- Reset mid-operation abandons any outstanding request. Instruction memory must accept an abandoned request.

## Timing
- With zero-wait memory (`imem_ready`=1): one instruction per cycle, with IF/ID updated on the edge after the request.
- A taken redirect costs 1 bubble with the macro undefined, and 0 bubbles with it defined.
- Each memory wait cycle adds one bubble (`if_valid`=0).
- Redirect and `stall` are never asserted together; if they are, `stall` wins and the redirect is ignored.
- `imem_addr` is driven from the pc register, or from the held address in WAIT/DROP. It carries no combinational path from the redirect inputs.

## Configuration
- `BRANCH_DELAY_SLOT_EN` defined:
  - The word at branch/jump+4 is fetched and delivered with `if_valid`=1.
  - The redirect is latched into a pending register and applied as next_pc once that word is captured, including across WAIT and HOLD.
  - DROP is never entered.
- Undefined: squash behaviour as in Operation; the pending register is used only by DROP.

## Test plan
- Reset with `RESET_PC`=32'h0000_0040 and `imem_ready`=1 → addresses 0x40, 0x44, 0x48 on consecutive cycles; `if_valid`=0 in the first cycle after reset, then 1.
- Ready delayed 2 cycles on address 0x8 → `imem_addr` held at 0x8 for 3 cycles, two bubbles, then `if_instr`=word@0x8 and `if_pc4`=0xC.
- BEQ at 0x10 with `branch_target`=0x100 (macro undefined) → word@0x14 squashed with `if_valid`=0, next request 0x100. Macro defined → word@0x14 delivered valid, then 0x100.
- J with `if_instr[25:0]`=26'h0000040 and `if_pc4`=0x1000_0004 → next fetch 0x1000_0100. Redirect issued during WAIT (macro undefined) → one DROP response discarded, then fetch 0x1000_0100.
- `stall`=1 raised while WAIT and ready arrives → HOLD, `imem_req`=0, IF/ID unchanged. When `stall` drops → buffered word delivered with no new memory access.
- `reset` asserted during WAIT → next cycle `imem_req`=0, `if_valid`=0, pc=`RESET_PC`. A late `imem_ready` is ignored.
